// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the bit-serial sequence detectors; words stream gap-free.
// Define SEQ_SER_LSB_FIRST_EN for LSB-first shift order (default build is MSB-first).
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             seq,
    output logic             seq_valid,
    output logic             seq_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             seq_q, seq_d;
    logic             seq_valid_q, seq_valid_d;
    logic             seq_last_q, seq_last_d;
    logic             accept;

`ifdef SEQ_SER_LSB_FIRST_EN
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return w >> 1;
    endfunction
`else
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return w << 1;
    endfunction
`endif

    // Ready only from registered state so upstream never sees a loop through din_valid.
    assign din_ready = !rst && ((state_q == IDLE) || (cnt_q == LAST));
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        seq_valid_d = seq_valid_q;
        seq_last_d  = seq_last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SHIFT;
                    shreg_d     = din;
                    cnt_d       = '0;
                    seq_d       = first_bit(din);
                    seq_valid_d = 1'b1;
                    seq_last_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    // Reload in the last-bit cycle keeps seq_valid continuous across words.
                    if (accept) begin
                        shreg_d     = din;
                        cnt_d       = '0;
                        seq_d       = first_bit(din);
                        seq_valid_d = 1'b1;
                        seq_last_d  = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        seq_d       = IDLE_BIT;
                        seq_valid_d = 1'b0;
                        seq_last_d  = 1'b0;
                    end
                end else begin
                    shreg_d    = shift_word(shreg_q);
                    cnt_d      = cnt_q + CW'(1);
                    seq_d      = first_bit(shift_word(shreg_q));
                    seq_last_d = (cnt_q == PENULT);
                end
            end
            default: begin
                state_d     = IDLE;
                seq_d       = IDLE_BIT;
                seq_valid_d = 1'b0;
                seq_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            seq_q       <= IDLE_BIT;
            seq_valid_q <= 1'b0;
            seq_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            seq_valid_q <= seq_valid_d;
            seq_last_q  <= seq_last_d;
        end
    end

    assign seq       = seq_q;
    assign seq_valid = seq_valid_q;
    assign seq_last  = seq_last_q;
    assign busy      = seq_valid_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: WIDTH=4 and WIDTH=8 instances plus an IDLE_BIT=1 instance.
module tb_seq_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;
    bit         mon_en = 1'b0;

    logic       rst4, dv4, rdy4, seq4, sv4, sl4, busy4;
    logic [3:0] din4;
    logic       rst8, dv8, rdy8, seq8, sv8, sl8, busy8;
    logic [7:0] din8;
    logic       rst1, dv1, rdy1, seq1, sv1, sl1, busy1;
    logic [3:0] din1;

    exp_t       q4[$];
    exp_t       q8[$];
    exp_t       e4, e8;
    logic [3:0] hist4 = 4'b0;
    int         det4 = 0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(4), .IDLE_BIT(1'b0)) u4 (
        .clk(clk), .rst(rst4), .din(din4), .din_valid(dv4), .din_ready(rdy4),
        .seq(seq4), .seq_valid(sv4), .seq_last(sl4), .busy(busy4)
    );

    seq_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) u8 (
        .clk(clk), .rst(rst8), .din(din8), .din_valid(dv8), .din_ready(rdy8),
        .seq(seq8), .seq_valid(sv8), .seq_last(sl8), .busy(busy8)
    );

    seq_serializer #(.WIDTH(4), .IDLE_BIT(1'b1)) u1 (
        .clk(clk), .rst(rst1), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .seq(seq1), .seq_valid(sv1), .seq_last(sl1), .busy(busy1)
    );

    // Expected emission order of a word: first n bits, last flag on the final bit.
    function automatic void push4(input logic [3:0] w);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
`ifdef SEQ_SER_LSB_FIRST_EN
            e.b = w[i];
`else
            e.b = w[3-i];
`endif
            e.last = (i == 3);
            q4.push_back(e);
        end
    endfunction

    function automatic void push8(input logic [7:0] w, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
`ifdef SEQ_SER_LSB_FIRST_EN
            e.b = w[i];
`else
            e.b = w[7-i];
`endif
            e.last = (i == 7);
            q8.push_back(e);
        end
    endfunction

    // Scoreboard: every valid bit is popped and compared; a downstream 1101 detector counts hits.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sv4) begin
                hist4 = {hist4[2:0], seq4};
                if (hist4 == 4'b1101) det4++;
                n_total++;
                if (q4.size() == 0) begin
                    $display("FAIL u4_extra_bit: got valid seq=%b, required no valid bit", seq4);
                end else begin
                    e4 = q4.pop_front();
                    if (seq4 !== e4.b || sl4 !== e4.last)
                        $display("FAIL u4_bit: got seq=%b last=%b, required seq=%b last=%b", seq4, sl4, e4.b, e4.last);
                    else n_pass++;
                end
            end else begin
                n_total++;
                if (seq4 !== 1'b0 || sl4 !== 1'b0)
                    $display("FAIL u4_idle: got seq=%b last=%b, required 0 0", seq4, sl4);
                else n_pass++;
            end
            n_total++;
            if (busy4 !== sv4) $display("FAIL u4_busy: got %b, required %b", busy4, sv4);
            else n_pass++;
            if (sv8) begin
                n_total++;
                if (q8.size() == 0) begin
                    $display("FAIL u8_extra_bit: got valid seq=%b, required no valid bit", seq8);
                end else begin
                    e8 = q8.pop_front();
                    if (seq8 !== e8.b || sl8 !== e8.last)
                        $display("FAIL u8_bit: got seq=%b last=%b, required seq=%b last=%b", seq8, sl8, e8.b, e8.last);
                    else n_pass++;
                end
            end
        end
    end

    task automatic send4(input logic [3:0] w, output bit ok);
        din4 = w;
        dv4  = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy4) begin
                push4(w);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst8 = 1'b1; rst1 = 1'b1;
        dv4 = 1'b0; dv8 = 1'b0; dv1 = 1'b0;
        din4 = '0; din8 = '0; din1 = '0;
        @(posedge clk);
        #1;
        n_total++; if (seq4 !== 1'b0) $display("FAIL rst_seq: got %b, required 0", seq4); else n_pass++;
        n_total++; if (sv4 !== 1'b0) $display("FAIL rst_seq_valid: got %b, required 0", sv4); else n_pass++;
        n_total++; if (sl4 !== 1'b0) $display("FAIL rst_seq_last: got %b, required 0", sl4); else n_pass++;
        n_total++; if (busy4 !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy4); else n_pass++;
        n_total++; if (rdy4 !== 1'b0) $display("FAIL rst_ready_low: got %b, required 0", rdy4); else n_pass++;
        n_total++; if (sv8 !== 1'b0) $display("FAIL rst_u8_valid: got %b, required 0", sv8); else n_pass++;
        rst4 = 1'b0;
        rst8 = 1'b0;
        #1;
        n_total++; if (rdy4 !== 1'b1) $display("FAIL rst_ready_after: got %b, required 1", rdy4); else n_pass++;
        n_total++; if (rdy8 !== 1'b1) $display("FAIL rst_u8_ready_after: got %b, required 1", rdy8); else n_pass++;
        mon_en = 1'b1;
    endtask

    task automatic test_idle_bit();
        n_total++; if (seq1 !== 1'b1) $display("FAIL idle1_in_rst: got %b, required 1", seq1); else n_pass++;
        n_total++; if (sv1 !== 1'b0) $display("FAIL idle1_valid_in_rst: got %b, required 0", sv1); else n_pass++;
        rst1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (seq1 !== 1'b1) $display("FAIL idle1_seq: got %b, required 1", seq1); else n_pass++;
        n_total++; if (sv1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL idle1_valid: got %b/%b, required 0/0", sv1, busy1); else n_pass++;
        n_total++; if (rdy1 !== 1'b1) $display("FAIL idle1_ready: got %b, required 1", rdy1); else n_pass++;
    endtask

    task automatic test_single();
        bit ok;
        int nv = 0;
        send4(4'b1101, ok);
        dv4 = 1'b0;
        n_total++; if (ok !== 1'b1) $display("FAIL single_accept: got %b, required 1", ok); else n_pass++;
        n_total++; if (sv4 !== 1'b1) $display("FAIL single_latency: got valid %b, required 1", sv4); else n_pass++;
        for (int i = 0; i < 12 && q4.size() != 0; i++) begin
            @(negedge clk);
            if (sv4) nv++;
            @(posedge clk);
            #1;
        end
        n_total++; if (q4.size() != 0) $display("FAIL single_drain: got %0d left, required 0", q4.size()); else n_pass++;
        n_total++; if (nv != 4) $display("FAIL single_valid_cycles: got %0d, required 4", nv); else n_pass++;
        n_total++; if (sv4 !== 1'b0 || seq4 !== 1'b0) $display("FAIL single_end_idle: got %b/%b, required 0/0", sv4, seq4); else n_pass++;
        n_total++; if (rdy4 !== 1'b1) $display("FAIL single_end_ready: got %b, required 1", rdy4); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit second = 1'b0;
        int nv = 0;
        hist4 = 4'b0;
        det4 = 0;
        send4(4'b1101, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL b2b_accept1: got %b, required 1", ok); else n_pass++;
        din4 = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sv4) nv++;
            if (!second && rdy4) begin
                n_total++; if (sl4 !== 1'b1) $display("FAIL b2b_accept_in_last: got last=%b, required 1", sl4); else n_pass++;
                push4(4'b1011);
                second = 1'b1;
            end
            @(posedge clk);
            #1;
            if (second) dv4 = 1'b0;
        end
        n_total++; if (second !== 1'b1) $display("FAIL b2b_accept2: got %b, required 1", second); else n_pass++;
        n_total++; if (nv != 8) $display("FAIL b2b_contiguous: got %0d valid cycles, required 8", nv); else n_pass++;
        n_total++; if (q4.size() != 0) $display("FAIL b2b_drain: got %0d left, required 0", q4.size()); else n_pass++;
        n_total++; if (sv4 !== 1'b0) $display("FAIL b2b_end_idle: got %b, required 0", sv4); else n_pass++;
`ifndef SEQ_SER_LSB_FIRST_EN
        n_total++; if (det4 != 2) $display("FAIL b2b_detect_1101: got %0d pulses, required 2", det4); else n_pass++;
`endif
    endtask

    task automatic test_stall();
        bit ok;
        send4(4'b1111, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL stall_accept1: got %b, required 1", ok); else n_pass++;
        dv4 = 1'b0;
        @(posedge clk);
        #1;
        din4 = 4'b1001;
        dv4  = 1'b1;
        @(negedge clk);
        n_total++; if (rdy4 !== 1'b0) $display("FAIL stall_ready_bit2: got %b, required 0", rdy4); else n_pass++;
        @(posedge clk);
        #1;
        din4 = 4'b0110;
        @(negedge clk);
        n_total++; if (rdy4 !== 1'b0) $display("FAIL stall_ready_bit3: got %b, required 0", rdy4); else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++; if (rdy4 !== 1'b1 || sl4 !== 1'b1) $display("FAIL stall_ready_bit4: got ready=%b last=%b, required 1 1", rdy4, sl4); else n_pass++;
        push4(4'b0110);
        @(posedge clk);
        #1;
        dv4 = 1'b0;
        for (int i = 0; i < 12 && q4.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        n_total++; if (q4.size() != 0) $display("FAIL stall_drain: got %0d left, required 0", q4.size()); else n_pass++;
        n_total++; if (sv4 !== 1'b0) $display("FAIL stall_end_idle: got %b, required 0", sv4); else n_pass++;
    endtask

    task automatic test_reset_mid();
        din8 = 8'hA5;
        dv8  = 1'b1;
        @(negedge clk);
        n_total++; if (rdy8 !== 1'b1) $display("FAIL rmid_ready: got %b, required 1", rdy8); else n_pass++;
        push8(8'hA5, 3);
        @(posedge clk);
        #1;
        dv8 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (sv8 !== 1'b0 || seq8 !== 1'b0) $display("FAIL rmid_outputs: got valid=%b seq=%b, required 0 0", sv8, seq8); else n_pass++;
        n_total++; if (sl8 !== 1'b0 || busy8 !== 1'b0) $display("FAIL rmid_last_busy: got %b/%b, required 0/0", sl8, busy8); else n_pass++;
        n_total++; if (rdy8 !== 1'b0) $display("FAIL rmid_ready_in_rst: got %b, required 0", rdy8); else n_pass++;
        n_total++; if (q8.size() != 0) $display("FAIL rmid_partial: got %0d bits unseen, required 0", q8.size()); else n_pass++;
        rst8 = 1'b0;
        #1;
        n_total++; if (rdy8 !== 1'b1) $display("FAIL rmid_ready_after: got %b, required 1", rdy8); else n_pass++;
        din8 = 8'h3C;
        dv8  = 1'b1;
        @(negedge clk);
        push8(8'h3C, 8);
        @(posedge clk);
        #1;
        dv8 = 1'b0;
        for (int i = 0; i < 20 && q8.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        n_total++; if (q8.size() != 0) $display("FAIL rmid_new_word: got %0d left, required 0", q8.size()); else n_pass++;
        n_total++; if (sv8 !== 1'b0 || seq8 !== 1'b0) $display("FAIL rmid_end_idle: got %b/%b, required 0/0", sv8, seq8); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_bit();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the bit-serial sequence detectors. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `seq`. `seq` connects directly to the detector's `seq` input. Back-to-back words stream with no idle gap, so a pattern that straddles a word boundary reaches the detector intact. This matters for overlapping detection.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `IDLE_BIT`, 1'b0: value driven on `seq` when no word is being shifted.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `din`  in  WIDTH  parallel word. Sampled only on an accept cycle.
- `din_valid`  in  1  upstream has a word on `din`.
- `din_ready`  out  1  block can take a word this cycle. Combinational from state.
- `seq`  out  1  serial bit to the detector. Registered.
- `seq_valid`  out  1  `seq` carries a word bit this cycle. Registered.
- `seq_last`  out  1  current `seq` bit is the final bit of its word. Registered.
- `busy`  out  1  a word is in flight. Equals `seq_valid`.

## Operation
- State: `shreg[WIDTH-1:0]`, bit counter `cnt` of width `$clog2(WIDTH)`, and FSM states IDLE and SHIFT.
- Accept: the handshake completes when `din_valid && din_ready` is true at a rising edge.
- `din_ready` rules:
  - 1 in IDLE.
  - 1 in SHIFT only when `cnt == WIDTH-1`, i.e. during the last-bit cycle.
  - 0 otherwise.
  - Forced to 0 while `rst` is high.
- IDLE:
  - On accept, load `shreg <= din`, set `cnt <= 0`, go to SHIFT.
  - `seq` takes the first bit at the same edge.
  - Otherwise `seq = IDLE_BIT`, `seq_valid = 0`.
- SHIFT:
  - Each edge shifts `shreg` and increments `cnt`.
  - Default order is MSB-first: bit order on `seq` is `din[WIDTH-1]` down to `din[0]`.
  - `seq_last = 1` exactly when `cnt == WIDTH-1`.
- End of word, at the edge leaving `cnt == WIDTH-1`:
  - With an accept: reload from `din`, set `cnt <= 0`, stay in SHIFT. `seq_valid` stays 1 with no gap.
  - Without an accept: go to IDLE. `seq <= IDLE_BIT`, `seq_valid <= 0`, `seq_last <= 0`.
- `din_valid` while `din_ready` is 0: the word is not taken. Upstream holds `din`/`din_valid`; the block does not latch it early.
- `din` changes while it is not being accepted have no effect.
- Reset outputs: `seq = IDLE_BIT`, `seq_valid = 0`, `seq_last = 0`, `busy = 0`. Also `shreg = 0`, `cnt = 0`, state IDLE. `din_ready` is 0 during reset and 1 in the first cycle after `rst` deasserts.
- Reset mid-word: the partial word is discarded with no further bits. Outputs reach their reset values at the first edge with `rst` high.

## Timing
- Latency: a word accepted at edge k puts its first bit on `seq` in the cycle after edge k. The last bit appears after edge k+WIDTH-1.
- Throughput: one bit per clock. A new word every WIDTH cycles when `din_valid` is held.
- `din_ready` depends only on registered state and `rst`, never on `din_valid`, so there is no combinational loop with upstream.
- All outputs except `din_ready` are flop outputs.

## Configuration
- `SEQ_SER_LSB_FIRST_EN`:
  - Defined: shift order is LSB-first. `seq` emits `din[0]` first and `din[WIDTH-1]` last. `seq_last` still marks the final emitted bit.
  - Undefined (default): MSB-first as described above.
- Handshake and timing are identical in both builds.

## Test plan
- Single word, WIDTH=4:
  - Stimulus: after reset, one word `din=4'b1101`.
  - Required: `seq` = 1,1,0,1 on 4 consecutive cycles, `seq_valid` high for 4 cycles, `seq_last` only on the 4th. Then `seq=IDLE_BIT` and `din_ready=1`.
- Back-to-back:
  - Stimulus: WIDTH=4, `din_valid` held with 4'b1101 then 4'b1011.
  - Required: 8 contiguous valid bits 1,1,0,1,1,0,1,1. Second accept occurs in the `seq_last` cycle. A downstream 1101 overlapping detector pulses twice.
- Stall:
  - Stimulus: `din_valid` raised with 4'b0110 on the 2nd bit of a 4'b1111 word.
  - Required: `din_ready=0` until the 4th bit cycle. 0110 starts immediately after with no bit lost or duplicated.
- Reset mid-word:
  - Stimulus: WIDTH=8, `rst` asserted after 3 bits of 8'hA5.
  - Required: at the next edge `seq_valid=0` and `seq=IDLE_BIT`. After release, a new word 8'h3C shifts cleanly as 0,0,1,1,1,1,0,0.
- IDLE_BIT=1:
  - Stimulus: no input words.
  - Required: `seq=1` and `seq_valid=0` from reset onward.
- LSB-first build:
  - Stimulus: `SEQ_SER_LSB_FIRST_EN` defined, WIDTH=4, `din=4'b1101`.
  - Required: `seq` = 1,0,1,1 with `seq_last` on the 4th bit.
